hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage core. It generates the `stall` and `flush` inputs consumed by `control_unit` in ID, and drives the PC and IF/ID enables. It also implements the load-use bubble, the branch/jump redirect flush, the data-memory wait freeze, and the halt drain-and-stop sequence. Its inputs come from the ID, EX and MEM stage registers.

---
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: load-use bubble, redirect flush,
// data-memory wait freeze and halt drain-and-stop, plus saturating event counters.
module hazard_ctrl #(
  parameter int unsigned REG_AW       = 4,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              id_halt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_branch,
  input  logic              ex_taken,
  input  logic              ex_jump,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              stall,
  output logic              flush,
  output logic              redirect,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              freeze,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned DL_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DL_W-1:0]   drain_left_q, drain_left_d;
  logic              stall_inc, flush_inc;
  logic              wait_ev, redir_ev, lu_ev;

  // Hazard event decode
  assign wait_ev  = mem_req & ~mem_ready;
  assign redir_ev = (ex_branch & ex_taken) | ex_jump;
  assign lu_ev    = ex_mem_read & (ex_rd != '0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                     (id_uses_rs2 & (id_rs2 == ex_rd)));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      drain_left_q <= '0;
    end else begin
      state_q      <= state_d;
      drain_left_q <= drain_left_d;
    end
  end

  // Next state and pipeline control; a memory wait freezes everything but HALTED
  always_comb begin
    state_d      = state_q;
    drain_left_d = drain_left_q;
    stall        = 1'b0;
    flush        = 1'b0;
    redirect     = 1'b0;
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    freeze       = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    if (rst) begin
      flush = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (wait_ev) begin
            freeze = 1'b1;
          end else if (redir_ev) begin
            flush     = 1'b1;
            redirect  = 1'b1;
            pc_en     = 1'b1;
            ifid_en   = 1'b1;
            flush_inc = 1'b1;
          end else if (lu_ev) begin
            stall     = 1'b1;
            stall_inc = 1'b1;
          end else if (id_halt) begin
            stall        = 1'b1;
            state_d      = DRAIN;
            drain_left_d = DL_W'(DRAIN_CYCLES);
          end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
          end
        end
        DRAIN: begin
          if (wait_ev) begin
            freeze = 1'b1;
          end else if (redir_ev) begin
            // Halt was on a wrong path: resume fetching at the target
            flush        = 1'b1;
            redirect     = 1'b1;
            pc_en        = 1'b1;
            ifid_en      = 1'b1;
            flush_inc    = 1'b1;
            state_d      = RUN;
            drain_left_d = '0;
          end else begin
            stall        = 1'b1;
            drain_left_d = drain_left_q - DL_W'(1);
            if (drain_left_q <= DL_W'(1)) begin
              state_d      = HALTED;
              drain_left_d = '0;
            end
          end
        end
        HALTED: begin
          stall = 1'b1;
        end
        default: begin
          state_d      = RUN;
          drain_left_d = '0;
        end
      endcase
    end
  end

  assign halted = (state_q == HALTED) & ~rst;

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl; a rule-level model pushes expected
// outputs into a queue that a negedge monitor drains and compares.
module tb_hazard_ctrl;

  localparam int unsigned REG_AW = 4;
  localparam int unsigned DRAIN  = 3;
  localparam int unsigned CNT_W  = 16;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       rst;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic       u1;
    logic       u2;
    logic       halt;
    logic [3:0] rd;
    logic       mrd;
    logic       br;
    logic       tk;
    logic       jp;
    logic       mreq;
    logic       mrdy;
  } stim_t;

  typedef struct packed {
    logic [6:0]       outs;  // stall,flush,redirect,pc_en,ifid_en,freeze,halted
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
    logic             cnt_known;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, id_halt, ex_mem_read, ex_branch, ex_taken, ex_jump;
  logic mem_req, mem_ready;
  logic stall, flush, redirect, pc_en, ifid_en, freeze, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(REG_AW), .DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_halt(id_halt), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch(ex_branch), .ex_taken(ex_taken), .ex_jump(ex_jump),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .stall(stall), .flush(flush), .redirect(redirect), .pc_en(pc_en), .ifid_en(ifid_en),
    .freeze(freeze), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   end_check = 1'b0;

  // Reference model: mode 0=running, 1=draining, 2=stopped
  int m_mode = 0;
  int m_left = 0;
  int m_stall = 0;
  int m_flush = 0;
  bit m_known = 1'b0;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t rand_stim(int halt_div, int rst_div);
    stim_t s;
    s.rst  = (rst_div != 0) && ($urandom_range(rst_div - 1) == 0);
    s.rs1  = 4'($urandom_range(3));
    s.rs2  = 4'($urandom_range(3));
    s.u1   = 1'($urandom_range(1));
    s.u2   = 1'($urandom_range(1));
    s.halt = (halt_div != 0) && ($urandom_range(halt_div - 1) == 0);
    s.rd   = 4'($urandom_range(3));
    s.mrd  = ($urandom_range(2) == 0);
    s.br   = ($urandom_range(5) == 0);
    s.tk   = 1'($urandom_range(1));
    s.jp   = ($urandom_range(11) == 0);
    s.mreq = ($urandom_range(3) == 0);
    s.mrdy = 1'($urandom_range(1));
    return s;
  endfunction

  task automatic cycle(input stim_t s);
    exp_t e;
    bit st, fl, rd, pe, ie, fz, hl;
    bit wait_e, redir_e, lu_e;
    @(posedge clk);
    #1;
    cyc++;
    rst = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2; id_uses_rs1 = s.u1; id_uses_rs2 = s.u2;
    id_halt = s.halt; ex_rd = s.rd; ex_mem_read = s.mrd; ex_branch = s.br; ex_taken = s.tk;
    ex_jump = s.jp; mem_req = s.mreq; mem_ready = s.mrdy;

    wait_e  = s.mreq && !s.mrdy;
    redir_e = (s.br && s.tk) || s.jp;
    lu_e    = s.mrd && (s.rd != 0) && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    {st, fl, rd, pe, ie, fz, hl} = '0;
    e.sc = CNT_W'(m_stall);
    e.fc = CNT_W'(m_flush);
    e.cnt_known = m_known;
    e.cyc = cyc;

    if (s.rst) begin
      fl = 1;
      m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0; m_known = 1'b1;
    end else if (m_mode == 2) begin
      hl = 1; st = 1;
    end else if (wait_e) begin
      fz = 1;
    end else if (redir_e) begin
      fl = 1; rd = 1; pe = 1; ie = 1;
      m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : m_flush;
      m_mode = 0; m_left = 0;
    end else if (m_mode == 1) begin
      st = 1;
      if (m_left <= 1) begin m_mode = 2; m_left = 0; end
      else m_left--;
    end else if (lu_e) begin
      st = 1;
      m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
    end else if (s.halt) begin
      st = 1; m_mode = 1; m_left = DRAIN;
    end else begin
      pe = 1; ie = 1;
    end
    e.outs = {st, fl, rd, pe, ie, fz, hl};
    exp_q.push_back(e);
  endtask

  // Monitor: compare each cycle's outputs mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({stall, flush, redirect, pc_en, ifid_en, freeze, halted} != e.outs) begin
        errors++;
        $display("FAIL outs cyc=%0d got=%b exp=%b (stall,flush,redirect,pc_en,ifid_en,freeze,halted)",
                 e.cyc, {stall, flush, redirect, pc_en, ifid_en, freeze, halted}, e.outs);
      end
      if (e.cnt_known) begin
        checks++;
        if (stall_cnt != e.sc || flush_cnt != e.fc) begin
          errors++;
          $display("FAIL counters cyc=%0d got stall_cnt=%0d flush_cnt=%0d exp %0d %0d",
                   e.cyc, stall_cnt, flush_cnt, e.sc, e.fc);
        end
      end
    end
    if (end_check) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL drain got=%0d pending exp=0", exp_q.size());
      end
    end
  end

  initial begin
    stim_t s;
    rst = 1'b1; id_rs1 = '0; id_rs2 = '0; ex_rd = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_halt = 0; ex_mem_read = 0; ex_branch = 0; ex_taken = 0; ex_jump = 0;
    mem_req = 0; mem_ready = 0;

    s = idle(); s.rst = 1;
    repeat (2) cycle(s);
    s = rand_stim(4, 0); s.rst = 1;
    cycle(s);
    cycle(idle());

    // Load-use, then same with ex_rd=0
    s = idle(); s.mrd = 1; s.rd = 4'd3; s.rs2 = 4'd3; s.u2 = 1;
    cycle(s);
    cycle(idle());
    s.rd = 4'd0; s.rs2 = 4'd0;
    cycle(s);
    cycle(idle());

    // Taken branch together with a load-use hazard
    s = idle(); s.br = 1; s.tk = 1; s.mrd = 1; s.rd = 4'd2; s.rs1 = 4'd2; s.u1 = 1;
    cycle(s);
    cycle(idle());

    // Memory wait for 4 cycles while a redirect is pending
    s = idle(); s.jp = 1; s.mreq = 1; s.mrdy = 0;
    repeat (4) cycle(s);
    s.mrdy = 1;
    cycle(s);
    cycle(idle());

    // Halt then random traffic while stopped, then reset
    s = idle(); s.halt = 1;
    cycle(s);
    repeat (14) cycle(rand_stim(3, 0));
    s = idle(); s.rst = 1;
    cycle(s);
    cycle(idle());

    // Halt with a wait inside the drain
    s = idle(); s.halt = 1;
    cycle(s);
    cycle(idle());
    s = idle(); s.mreq = 1;
    repeat (2) cycle(s);
    repeat (4) cycle(idle());
    s = idle(); s.rst = 1;
    cycle(s);

    // Wrong-path halt: jump on the second drain cycle
    s = idle(); s.halt = 1;
    cycle(s);
    cycle(idle());
    s = idle(); s.jp = 1;
    cycle(s);
    repeat (5) cycle(idle());

    // Random traffic with occasional halt and reset
    repeat (3000) cycle(rand_stim(30, 150));

    // Stall counter saturation
    s = idle(); s.rst = 1;
    cycle(s);
    s = idle(); s.mrd = 1; s.rd = 4'd5; s.rs1 = 4'd5; s.u1 = 1;
    repeat (70000) cycle(s);
    repeat (3) cycle(idle());

    @(posedge clk);
    end_check = 1'b1;
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
